pc_sequencer: RTL and testbench

- Owns the program counter and consumes the 2-bit `pc_selection` code produced by the branch-control logic in EX.
- Computes next PC, squashes younger in-flight instructions on a redirect, and traps on misaligned targets.
- Sits between EX (redirect source) and IF (instruction-memory address).

---
 rtl/rv_ctrl_pkg.sv | 26 ++
 rtl/pc_target_mux.sv | 42 ++++
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared control-flow definitions: pc_selection encodings, sequencer states
// and the data width used by the fetch path.
package rv_ctrl_pkg;

  localparam int XLEN        = 32;
  localparam int FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_JALR   = 2'b01,
    PC_TARGET = 2'b10,
    PC_NONE   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_TRAP  = 2'b10
  } seq_state_e;

  // Any nonzero low bit means the target cannot be fetched as a 32-bit word.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Decodes the EX redirect request into a fetch target and flags targets that
// are not word aligned.
module pc_target_mux
  import rv_ctrl_pkg::*;
(
  input  logic            redirect_valid_i,
  input  logic [1:0]      pc_selection_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] alu_result_i,
  output logic            take_o,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);

  pc_sel_e sel;
  assign sel = pc_sel_e'(pc_selection_i);

  always_comb begin
    take_o   = 1'b0;
    target_o = branch_target_i;
    if (redirect_valid_i) begin
      case (sel)
        PC_TARGET: begin
          take_o   = 1'b1;
          target_o = branch_target_i;
        end
        // jalr discards bit 0 of rs1+imm before use.
        PC_JALR: begin
          take_o   = 1'b1;
          target_o = {alu_result_i[XLEN-1:1], 1'b0};
        end
        default: begin
          take_o   = 1'b0;
          target_o = branch_target_i;
        end
      endcase
    end
  end

  assign misaligned_o = take_o & is_misaligned(target_o);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: sequential fetch, EX redirects with a fixed-depth
// squash window, and a trap hold on misaligned redirect targets.
module pc_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int          FLUSH_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [1:0]      pc_selection,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] alu_result,
  input  logic            trap_ack,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            flush,
  output logic            misaligned_trap,
  output logic [XLEN-1:0] trap_pc
);

  seq_state_e             state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [XLEN-1:0]        trap_pc_q, trap_pc_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   flush_q, flush_d;
  logic                   fetch_valid_q, fetch_valid_d;
  logic                   trap_q, trap_d;

  logic                   take;
  logic [XLEN-1:0]        target;
  logic                   misaligned;
  logic [XLEN-1:0]        pc_inc;

  pc_target_mux u_target_mux (
    .redirect_valid_i (redirect_valid),
    .pc_selection_i   (pc_selection),
    .branch_target_i  (branch_target),
    .alu_result_i     (alu_result),
    .take_o           (take),
    .target_o         (target),
    .misaligned_o     (misaligned)
  );

  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    trap_pc_d     = trap_pc_q;
    cnt_d         = cnt_q;
    flush_d       = flush_q;
    fetch_valid_d = fetch_valid_q;
    trap_d        = 1'b0;
    case (state_q)
      ST_RUN: begin
        fetch_valid_d = 1'b1;
        flush_d       = 1'b0;
        if (take && misaligned) begin
          trap_pc_d     = target;
          trap_d        = 1'b1;
          flush_d       = 1'b1;
          fetch_valid_d = 1'b0;
          state_d       = ST_TRAP;
        end else if (take) begin
          // A redirect beats a concurrent stall: the fetched path is wrong anyway.
          pc_d    = target;
          cnt_d   = FLUSH_CNT_W'(FLUSH_DEPTH);
          flush_d = 1'b1;
          state_d = ST_FLUSH;
        end else if (!stall) begin
          pc_d = pc_inc;
        end
      end
      ST_FLUSH: begin
        fetch_valid_d = 1'b1;
        cnt_d         = cnt_q - 1'b1;
        if (!stall) begin
          pc_d = pc_inc;
        end
        // Flush was raised on entry, so it drops as the count reaches zero.
        if (cnt_q == FLUSH_CNT_W'(1)) begin
          flush_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          flush_d = 1'b1;
        end
      end
      ST_TRAP: begin
        fetch_valid_d = 1'b0;
        flush_d       = 1'b1;
        if (trap_ack) begin
          pc_d          = TRAP_VECTOR;
          flush_d       = 1'b0;
          fetch_valid_d = 1'b1;
          state_d       = ST_RUN;
        end
      end
      default: begin
        flush_d = 1'b0;
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      trap_pc_q     <= '0;
      cnt_q         <= '0;
      flush_q       <= 1'b0;
      fetch_valid_q <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      trap_pc_q     <= trap_pc_d;
      cnt_q         <= cnt_d;
      flush_q       <= flush_d;
      fetch_valid_q <= fetch_valid_d;
      trap_q        <= trap_d;
    end
  end

  assign pc              = pc_q;
  assign pc_plus4        = pc_inc;
  assign fetch_valid     = fetch_valid_q;
  assign flush           = flush_q;
  assign misaligned_trap = trap_q;
  assign trap_pc         = trap_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential fetch, redirects, traps,
// stall interaction, pc wrap and reset during flush.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [1:0]  pc_selection;
  logic [31:0] branch_target;
  logic [31:0] alu_result;
  logic        trap_ack;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;
  logic        misaligned_trap;
  logic [31:0] trap_pc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100),
    .FLUSH_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .pc_selection    (pc_selection),
    .branch_target   (branch_target),
    .alu_result      (alu_result),
    .trap_ack        (trap_ack),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .fetch_valid     (fetch_valid),
    .flush           (flush),
    .misaligned_trap (misaligned_trap),
    .trap_pc         (trap_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks all registered outputs for one cycle and prints one line.
  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_flush,
                         input logic e_fv, input logic e_trap, input logic [31:0] e_tpc);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
    chk({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e_fv});
    chk({tag, ".misaligned_trap"}, {31'd0, misaligned_trap}, {31'd0, e_trap});
    chk({tag, ".trap_pc"}, trap_pc, e_tpc);
    $display("[%0t] %s pc=%h flush=%0b fv=%0b trap=%0b trap_pc=%h", $time, tag, pc, flush,
             fetch_valid, misaligned_trap, trap_pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [1:0] sel, input logic [31:0] bt, input logic [31:0] alu);
    redirect_valid = 1'b1;
    pc_selection   = sel;
    branch_target  = bt;
    alu_result     = alu;
  endtask

  task automatic no_redir();
    redirect_valid = 1'b0;
    pc_selection   = 2'b11;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; trap_ack = 1'b0;
    redirect_valid = 1'b0; pc_selection = 2'b11;
    branch_target = '0; alu_result = '0;
    tick(); tick();
    chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset.pc_plus4", pc_plus4, 32'h4);

    // Sequential fetch after reset release
    rst = 1'b0;
    tick(); chk_all("seq1", 32'h4, 1'b0, 1'b1, 1'b0, 32'h0);
    tick(); chk_all("seq2", 32'h8, 1'b0, 1'b1, 1'b0, 32'h0);
    tick(); chk_all("seq3", 32'hC, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (13) tick();
    chk_all("at40", 32'h40, 1'b0, 1'b1, 1'b0, 32'h0);

    // Taken branch, with a second redirect injected during FLUSH
    redir(2'b10, 32'h80, 32'h0);
    tick(); chk_all("br.f1", 32'h80, 1'b1, 1'b1, 1'b0, 32'h0);
    redir(2'b10, 32'h500, 32'h0);
    tick(); chk_all("br.f2", 32'h84, 1'b1, 1'b1, 1'b0, 32'h0);
    no_redir();
    tick(); chk_all("br.run", 32'h88, 1'b0, 1'b1, 1'b0, 32'h0);
    tick(); chk_all("br.run2", 32'h8C, 1'b0, 1'b1, 1'b0, 32'h0);

    // jalr with bit 0 cleared
    redir(2'b01, 32'h0, 32'h101);
    tick(); chk_all("jalr.f1", 32'h100, 1'b1, 1'b1, 1'b0, 32'h0);
    no_redir();
    tick(); chk_all("jalr.f2", 32'h104, 1'b1, 1'b1, 1'b0, 32'h0);
    tick(); chk_all("jalr.run", 32'h108, 1'b0, 1'b1, 1'b0, 32'h0);

    // Misaligned target -> trap; stall and redirect ignored while trapped
    redir(2'b10, 32'h102, 32'h0);
    tick(); chk_all("trap.pulse", 32'h108, 1'b1, 1'b0, 1'b1, 32'h102);
    no_redir();
    tick(); chk_all("trap.hold1", 32'h108, 1'b1, 1'b0, 1'b0, 32'h102);
    stall = 1'b1;
    redir(2'b10, 32'h600, 32'h0);
    tick(); chk_all("trap.hold2", 32'h108, 1'b1, 1'b0, 1'b0, 32'h102);
    stall = 1'b0;
    no_redir();
    trap_ack = 1'b1;
    tick(); chk_all("trap.ack", 32'h100, 1'b0, 1'b1, 1'b0, 32'h102);
    tick(); chk_all("ack.in_run", 32'h104, 1'b0, 1'b1, 1'b0, 32'h102);
    trap_ack = 1'b0;

    // Redirect together with stall, then stall alone
    stall = 1'b1;
    redir(2'b10, 32'h200, 32'h0);
    tick(); chk_all("stl.redir", 32'h200, 1'b1, 1'b1, 1'b0, 32'h102);
    no_redir();
    tick(); chk_all("stl.f2", 32'h200, 1'b1, 1'b1, 1'b0, 32'h102);
    tick(); chk_all("stl.exp", 32'h200, 1'b0, 1'b1, 1'b0, 32'h102);
    tick(); chk_all("stl.run", 32'h200, 1'b0, 1'b1, 1'b0, 32'h102);
    stall = 1'b0;
    tick(); chk_all("stl.rel", 32'h204, 1'b0, 1'b1, 1'b0, 32'h102);

    // Valid EX instruction with 00 / 11 is not a redirect
    redir(2'b00, 32'h700, 32'h0);
    tick(); chk_all("sel00", 32'h208, 1'b0, 1'b1, 1'b0, 32'h102);
    redir(2'b11, 32'h700, 32'h704);
    tick(); chk_all("sel11", 32'h20C, 1'b0, 1'b1, 1'b0, 32'h102);

    // Wrap at top of address space
    redir(2'b10, 32'hFFFF_FFF4, 32'h0);
    tick(); chk_all("wrap.f1", 32'hFFFF_FFF4, 1'b1, 1'b1, 1'b0, 32'h102);
    no_redir();
    tick(); chk_all("wrap.f2", 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0, 32'h102);
    tick(); chk_all("wrap.top", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'h102);
    chk("wrap.pc_plus4", pc_plus4, 32'h0);
    tick(); chk_all("wrap.zero", 32'h0, 1'b0, 1'b1, 1'b0, 32'h102);

    // Reset asserted mid-FLUSH
    redir(2'b10, 32'h300, 32'h0);
    tick(); chk_all("rstf.f1", 32'h300, 1'b1, 1'b1, 1'b0, 32'h102);
    no_redir();
    rst = 1'b1;
    tick(); chk_all("rstf.rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    tick(); chk_all("rstf.run", 32'h4, 1'b0, 1'b1, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
